// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Generic pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. in_ready is taken straight from a register
// (the skid-occupied flag), so back-pressure never forms a combinational
// path from out_ready to in_ready.
// Also provides a synchronous flush (bubble insert) and programmable
// payload/PC values after reset or flush.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low (0 = reset)
//   flush      synchronous kill of stage contents; overrides handshakes
//   in_valid   upstream presents a word
//   in_ready   stage can accept a word this cycle
//   in_data    upstream payload   [DATA_W]
//   in_pc      upstream PC        [PC_W]
//   out_valid  stage presents a word downstream
//   out_ready  downstream accepts this cycle
//   out_data   registered payload [DATA_W]
//   out_pc     registered PC      [PC_W]
//   count      occupancy 0..2
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           PC_W     = 32,
  parameter logic [DATA_W-1:0]     DATA_RST = 32'h0000_0000,
  parameter logic [PC_W-1:0]       PC_RST   = 32'h0000_3004
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        count
);

  // Encoding chosen so bit 0 is main_v and bit 1 is skid_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_d_reg, main_d_next;
  logic [PC_W-1:0]   main_pc_reg, main_pc_next;
  logic [DATA_W-1:0] skid_d_reg, skid_d_next;
  logic [PC_W-1:0]   skid_pc_reg, skid_pc_next;

  logic main_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;

  assign main_v    = state_reg[0];
  assign skid_v    = state_reg[1];
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d_reg;
  assign out_pc    = main_pc_reg;
  assign count     = {1'b0, main_v} + {1'b0, skid_v};
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= EMPTY;
      main_d_reg  <= DATA_RST;
      main_pc_reg <= PC_RST;
      skid_d_reg  <= DATA_RST;
      skid_pc_reg <= PC_RST;
    end else begin
      state_reg   <= state_next;
      main_d_reg  <= main_d_next;
      main_pc_reg <= main_pc_next;
      skid_d_reg  <= skid_d_next;
      skid_pc_reg <= skid_pc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    main_d_next  = main_d_reg;
    main_pc_next = main_pc_reg;
    skid_d_next  = skid_d_reg;
    skid_pc_next = skid_pc_reg;

    if (flush) begin
      // Any word accepted this cycle is dropped; a word leaving this cycle
      // has already been taken by the downstream stage.
      state_next   = EMPTY;
      main_d_next  = DATA_RST;
      main_pc_next = PC_RST;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            main_d_next  = in_data;
            main_pc_next = in_pc;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d_next  = in_data;
            main_pc_next = in_pc;
          end else if (in_fire) begin
            // Downstream stalled: park the new word behind main.
            skid_d_next  = in_data;
            skid_pc_next = in_pc;
            state_next   = FULL;
          end else if (out_fire) begin
            // main_d/main_pc keep the delivered word as a harmless bubble.
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d_next  = skid_d_reg;
            main_pc_next = skid_pc_reg;
            state_next   = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
  localparam logic [31:0] DRST = 32'h0000_0000;
  localparam logic [31:0] PRST = 32'h0000_3004;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(
    .DATA_W(32), .PC_W(32), .DATA_RST(DRST), .PC_RST(PRST)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: a FIFO of at most two words -------
  logic [31:0] q_d[$];
  logic [31:0] q_pc[$];
  logic [31:0] last_d, last_pc;
  bit          m_inf, m_outf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_d.delete(); q_pc.delete();
      last_d = DRST; last_pc = PRST;
    end else begin
      m_inf  = in_valid && (q_d.size() < 2);
      m_outf = out_ready && (q_d.size() > 0);
      if (flush) begin
        q_d.delete(); q_pc.delete();
        last_d = DRST; last_pc = PRST;
      end else begin
        if (m_outf) begin
          last_d  = q_d.pop_front();
          last_pc = q_pc.pop_front();
        end
        if (m_inf) begin
          q_d.push_back(in_data);
          q_pc.push_back(in_pc);
        end
      end
    end
  end

  function automatic logic [31:0] exp_data();
    return (q_d.size() > 0) ? q_d[0] : last_d;
  endfunction
  function automatic logic [31:0] exp_pc();
    return (q_pc.size() > 0) ? q_pc[0] : last_pc;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model -----------------
  always @(negedge clk) begin
    cmp("m_out_valid", {31'b0, out_valid}, {31'b0, (q_d.size() > 0)});
    cmp("m_in_ready",  {31'b0, in_ready},  {31'b0, (q_d.size() < 2)});
    cmp("m_count",     {30'b0, count},     q_d.size());
    cmp("m_out_data",  out_data, exp_data());
    cmp("m_out_pc",    out_pc,   exp_pc());
    $display("cyc t=%0t v=%0b r=%0b cnt=%0d data=%08h pc=%08h",
             $time, out_valid, in_ready, count, out_data, out_pc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] pc);
    in_valid = 1'b1; in_data = d; in_pc = pc;
    tick();
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_data = '0; in_pc = '0;
  endtask

  bit fired;
  logic [31:0] nd;

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_pc = '0;
    out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    cmp("rst_out_valid", {31'b0, out_valid}, 32'd0);
    cmp("rst_in_ready",  {31'b0, in_ready},  32'd1);
    cmp("rst_count",     {30'b0, count},     32'd0);
    cmp("rst_out_data",  out_data, 32'h0000_0000);
    cmp("rst_out_pc",    out_pc,   32'h0000_3004);

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'h2008_0001 + i, 32'h3004 + 4 * i);
      cmp("str_data",  out_data, 32'h2008_0001 + i);
      cmp("str_pc",    out_pc,   32'h3004 + 4 * i);
      cmp("str_count", {30'b0, count}, 32'd1);
      cmp("str_ready", {31'b0, in_ready}, 32'd1);
    end
    idle_in(); tick();
    cmp("str_drain_valid", {31'b0, out_valid}, 32'd0);
    cmp("str_hold_data",   out_data, 32'h2008_0004);

    // Back-pressure
    out_ready = 1'b0;
    push(32'h1111_1111, 32'h100);
    push(32'h2222_2222, 32'h104);
    cmp("bp_count", {30'b0, count}, 32'd2);
    cmp("bp_ready", {31'b0, in_ready}, 32'd0);
    cmp("bp_data_a", out_data, 32'h1111_1111);
    push(32'h3333_3333, 32'h108);   // C offered, must be ignored
    tick();
    cmp("bp_hold_a", out_data, 32'h1111_1111);
    cmp("bp_hold_cnt", {30'b0, count}, 32'd2);
    out_ready = 1'b1;
    tick();                          // A leaves, B moves up
    cmp("bp_data_b", out_data, 32'h2222_2222);
    tick();                          // B leaves, C accepted
    cmp("bp_data_c", out_data, 32'h3333_3333);
    cmp("bp_pc_c",   out_pc,   32'h108);
    idle_in(); tick();
    cmp("bp_empty", {30'b0, count}, 32'd0);

    // Flush while full
    out_ready = 1'b0;
    push(32'hAAAA_0001, 32'h200);
    push(32'hBBBB_0002, 32'h204);
    flush = 1'b1;
    push(32'hCCCC_0003, 32'h208);
    flush = 1'b0; idle_in();
    cmp("fl_valid", {31'b0, out_valid}, 32'd0);
    cmp("fl_count", {30'b0, count}, 32'd0);
    cmp("fl_data",  out_data, 32'h0);
    cmp("fl_pc",    out_pc,   32'h3004);
    cmp("fl_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    cmp("fl_no_emit", {31'b0, out_valid}, 32'd0);

    // Simultaneous fire in ONE
    out_ready = 1'b0;
    push(32'h0A0A_0A0A, 32'h300);
    out_ready = 1'b1;
    push(32'h0B0B_0B0B, 32'h304);
    cmp("sim_data",  out_data, 32'h0B0B_0B0B);
    cmp("sim_count", {30'b0, count}, 32'd1);
    idle_in(); tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    push(32'h5555_5555, 32'h400);
    push(32'h6666_6666, 32'h404);
    idle_in();
    #3 rst = 1'b0;
    #1;
    cmp("ar_valid", {31'b0, out_valid}, 32'd0);
    cmp("ar_count", {30'b0, count}, 32'd0);
    cmp("ar_ready", {31'b0, in_ready}, 32'd1);
    cmp("ar_data",  out_data, 32'h0);
    cmp("ar_pc",    out_pc,   32'h3004);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    push(32'h7777_7777, 32'h500);
    cmp("ar_lat_valid", {31'b0, out_valid}, 32'd1);
    cmp("ar_lat_data",  out_data, 32'h7777_7777);
    idle_in(); tick();

    // Mixed traffic, upstream holds its word until accepted
    nd = 32'h9000_0000;
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i % 4) != 1;
      out_ready = (i % 3) != 0;
      flush     = (i == 23);
      in_data   = nd;
      in_pc     = nd + 32'h10;
      fired     = in_valid && in_ready;
      tick();
      if (fired) nd = nd + 1;
    end
    flush = 1'b0; idle_in(); out_ready = 1'b1;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
